mem_io_bridge: RTL

// - Sits directly downstream of the cpu top's memory bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
// - Decodes each byte access to 128KB RAM or the I/O window (a[17:16]==2'b11).
// - Buffers UART TX bytes in a FIFO and drives io_buffer_full back-pressure.
// - Serves UART RX bytes, a 32-bit cycle counter and the program-stop flag.

---
 rtl/mem_io_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_bridge
// Purpose  : CPU byte bus bridge to 128KB RAM and a small I/O window
//            (UART TX FIFO, UART RX, cycle counter, program-stop flag).
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_bridge #(
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_wdat,
    input  logic [7:0]  ram_rdat,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        prog_stop
);

    localparam int                 C_PTR_W  = $clog2(TX_DEPTH);
    localparam int                 C_CNT_W  = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH  = C_CNT_W'(TX_DEPTH);
    localparam logic [C_CNT_W-1:0] C_THRESH = C_CNT_W'(TX_DEPTH - FULL_MARGIN);

    logic               w_io, w_a_rx, w_a_cnt, w_a_stop, w_wr, w_rd;
    logic               w_push_req, w_push, w_pop, w_full;
    logic               w_unused;

    logic               sel_ram_q, sel_ram_d;
    logic [7:0]         io_rdat_q, io_rdat_d;
    logic [31:0]        latch_q, latch_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               stop_req_q, stop_req_d;
    logic               prog_stop_q, prog_stop_d;
    logic               ibf_q, ibf_d;
    logic [7:0]         mem_q [TX_DEPTH];

    assign w_unused = ^cpu_a[31:18];

    assign w_io     = (cpu_a[17:16] == 2'b11);
    assign w_a_rx   = (cpu_a[17:0] == 18'h30000);
    assign w_a_cnt  = (cpu_a[17:2] == 16'hC001);
    assign w_a_stop = (cpu_a[17:0] == 18'h30004);
    assign w_wr     = en & cpu_wr;
    assign w_rd     = en & ~cpu_wr;

    // Strobes are qualified with the reset pin so every output is quiet in reset.
    assign ram_a    = cpu_a[16:0];
    assign ram_wdat = cpu_dout;
    assign ram_we   = rst & w_wr & ~w_io;
    assign rx_pop   = rst & w_rd & w_a_rx & rx_valid;

    assign cpu_din        = sel_ram_q ? ram_rdat : io_rdat_q;
    assign tx_valid       = (count_q != '0);
    assign tx_data        = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign io_buffer_full = ibf_q;
    assign prog_stop      = prog_stop_q;

    assign w_full     = (count_q == C_DEPTH);
    assign w_pop      = tx_valid & tx_ready;
    assign w_push_req = w_wr & w_a_rx & (cpu_dout != 8'h00);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_comb begin
        sel_ram_d = sel_ram_q;
        io_rdat_d = io_rdat_q;
        latch_d   = latch_q;
        cnt_d     = en ? cnt_q + 32'd1 : cnt_q;
        if (w_rd) begin
            sel_ram_d = ~w_io;
            io_rdat_d = 8'h00;
            if (w_a_rx) begin
                io_rdat_d = rx_valid ? rx_data : 8'h00;
            end else if (w_a_cnt) begin
                case (cpu_a[1:0])
                    2'd0: begin
                        io_rdat_d = cnt_q[7:0];
                        latch_d   = cnt_q;
                    end
                    2'd1:    io_rdat_d = latch_q[15:8];
                    2'd2:    io_rdat_d = latch_q[23:16];
                    default: io_rdat_d = latch_q[31:24];
                endcase
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + C_PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + C_PTR_W'(w_pop);
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d       = ovf_q | (w_push_req & ~w_push);
        stop_req_d  = stop_req_q | (w_wr & w_a_stop);
        prog_stop_d = prog_stop_q | (stop_req_d & (count_d == '0));
        ibf_d       = (count_q >= C_THRESH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_ram_q   <= 1'b0;
            io_rdat_q   <= 8'h00;
            latch_q     <= 32'h0;
            cnt_q       <= 32'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            stop_req_q  <= 1'b0;
            prog_stop_q <= 1'b0;
            ibf_q       <= 1'b0;
        end else begin
            sel_ram_q   <= sel_ram_d;
            io_rdat_q   <= io_rdat_d;
            latch_q     <= latch_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            stop_req_q  <= stop_req_d;
            prog_stop_q <= prog_stop_d;
            ibf_q       <= ibf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= cpu_dout;
        end
    end

endmodule
`default_nettype wire
